pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the group's single-cycle CPU, replacing the fixed 32-bit PC register, PC+4 adder, branch adder and branch select mux. It gives one cycle-accurate next-PC decision per retired instruction. It stalls on data-memory or instruction-memory busywait, supports jump, beq, bne and a new halt mode, and keeps saturating retire and taken-branch counters for performance checks. It sits between the control unit/ALU (branch inputs) and the instruction cache (PC output).

## Interface
- PC_W, default 32: PC width in bits.
- OFF_W, default 8: signed branch/jump offset width, taken from the instruction target field.
- INSTR_BYTES, default 4: sequential PC increment.
- ALIGN_SHIFT, default 2: left shift applied to the sign-extended offset.
- RESET_VEC, default 0: PC value loaded by reset.
- CNT_W, default 16: width of each performance counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUSYWAIT  in  1  data-memory stall request.
- INSBUSYWAIT  in  1  instruction-memory stall request.
- JUMP  in  1  the current instruction is an unconditional jump.
- BRANCH_EQ  in  1  the current instruction is beq.
- BRANCH_NE  in  1  the current instruction is bne.
- ALUZERO  in  1  ALU zero flag for the current instruction.
- HALT  in  1  the current instruction is halt.
- OFFSET  in  OFF_W  signed word offset.
- PC  out  PC_W  address of the current instruction (registered).
- PC_NEXT  out  PC_W  PC+INSTR_BYTES (combinational); used as the link value.
- FETCH_VALID  out  1  the instruction at PC retires this cycle.
- STALL  out  1  the sequencer is in STALL state.
- HALTED  out  1  the sequencer is in HALTED state.
- RETIRE_CNT  out  CNT_W  retired instructions, saturating.
- TAKEN_CNT  out  CNT_W  taken jumps and branches, saturating.

## Operation
- FSM states:
  - BOOT: entered from reset; one cycle; no retire; always goes to RUN.
  - RUN: normal operation.
  - STALL: waiting on a busywait.
  - HALTED: frozen.
- retire = state∈{RUN,STALL} & !BUSYWAIT & !INSBUSYWAIT.
- FETCH_VALID = retire.
- RUN with either busywait high: go to STALL; PC holds.
- STALL with both busywaits low: retire and go to RUN.
- taken = JUMP | (BRANCH_EQ & ALUZERO) | (BRANCH_NE & !ALUZERO).
- target = PC_NEXT + (sext(OFFSET) << ALIGN_SHIFT). All PC arithmetic is modulo 2^PC_W; there is no overflow flag.
- On retire:
  - HALT=1: PC holds, RETIRE_CNT increments, state goes to HALTED. HALT has priority over taken, and TAKEN_CNT does not increment.
  - HALT=0: PC <= taken ? target : PC_NEXT. RETIRE_CNT increments, and TAKEN_CNT increments if taken.
- HALTED: PC and both counters are frozen; every input except RESET is ignored.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Control inputs are sampled only on a retire cycle; their values during stall cycles have no effect.

## Timing
- Reset values, one edge after RESET high: PC=RESET_VEC, state=BOOT, FETCH_VALID=0, STALL=0, HALTED=0, RETIRE_CNT=0, TAKEN_CNT=0. PC_NEXT=RESET_VEC+INSTR_BYTES.
- RESET has priority over every other input in every state, including STALL and HALTED. A reset asserted mid-stall discards the pending instruction.
- Latency: inputs on a retire cycle determine the PC seen after the next rising edge. The first retire is possible on the second edge after RESET falls, because of BOOT.
- Both busywaits are level-sensitive. A stall lasting N cycles delays the PC update by exactly N edges.
- BUSYWAIT and INSBUSYWAIT high together count as a single stall; the sequencer leaves STALL only when both are low.

## Structure
- Shared package cpu_pkg:
  - seq_state_t enum {BOOT, RUN, STALL, HALTED}.
  - Default parameter constants.
- Sub-module pc_target_adder (PC_W, OFF_W, ALIGN_SHIFT): combinational; produces PC_NEXT and target.
- The FSM, PC register and counters live in pc_sequencer.

## Test plan
- Reset then 3 retires, no stalls: PC goes 0→4→8→12; RETIRE_CNT=3; TAKEN_CNT=0.
- At PC=0x10: beq with ALUZERO=1, OFFSET=0xFE → PC=0x0C and TAKEN_CNT=1. bne with ALUZERO=1 → PC=0x14.
- At PC=0x20: BUSYWAIT high for 3 cycles with JUMP=1, OFFSET=0x02 → STALL=1 for 3 cycles and PC holds 0x20. When BUSYWAIT drops: PC=0x2C and TAKEN_CNT increments once.
- PC=0xFFFFFFFC, sequential retire → PC=0x00000000. With CNT_W=2, 5 retires → RETIRE_CNT=3.
- HALT together with JUMP at PC=0x40 → HALTED=1, PC stays 0x40 for 10 cycles, TAKEN_CNT unchanged.
- RESET during HALTED, and separately during an INSBUSYWAIT stall → all outputs return to their reset values on the next edge; BOOT then RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: sequencer states and default
// parameter values used by the PC sequencer and its target adder.
package cpu_pkg;

    // Program-counter sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    localparam int DEF_PC_W        = 32;
    localparam int DEF_OFF_W       = 8;
    localparam int DEF_INSTR_BYTES = 4;
    localparam int DEF_ALIGN_SHIFT = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC arithmetic: sequential successor (also the link
// value) and the PC-relative jump/branch target. Wraps modulo 2^PC_W.
module pc_target_adder #(
    parameter int PC_W        = 32,
    parameter int OFF_W       = 8,
    parameter int ALIGN_SHIFT = 2,
    parameter int INSTR_BYTES = 4
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic [OFF_W-1:0] i_offset,
    output logic [PC_W-1:0]  o_pc_next,
    output logic [PC_W-1:0]  o_target
);

    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_off_scaled;

    // Sign-extend the word offset to PC width, then scale to bytes.
    assign w_off_ext    = PC_W'($signed(i_offset));
    assign w_off_scaled = w_off_ext << ALIGN_SHIFT;

    // Targets are relative to the following instruction, not the current one.
    assign o_pc_next = i_pc + PC_W'(INSTR_BYTES);
    assign o_target  = o_pc_next + w_off_scaled;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, boot/run/stall/halt FSM and
// saturating retire / taken-branch performance counters.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter int              OFF_W       = DEF_OFF_W,
    parameter int              INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int              ALIGN_SHIFT = DEF_ALIGN_SHIFT,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic             INSBUSYWAIT,
    input  logic             JUMP,
    input  logic             BRANCH_EQ,
    input  logic             BRANCH_NE,
    input  logic             ALUZERO,
    input  logic             HALT,
    input  logic [OFF_W-1:0] OFFSET,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_NEXT,
    output logic             FETCH_VALID,
    output logic             STALL,
    output logic             HALTED,
    output logic [CNT_W-1:0] RETIRE_CNT,
    output logic [CNT_W-1:0] TAKEN_CNT
);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_target;
    logic            w_busy;
    logic            w_retire;
    logic            w_taken;

    // Counter 0 counts retires, counter 1 counts taken jumps/branches.
    logic [CNT_W-1:0] r_cnt [2];
    logic             w_cnt_inc [2];

    pc_target_adder #(
        .PC_W        (PC_W),
        .OFF_W       (OFF_W),
        .ALIGN_SHIFT (ALIGN_SHIFT),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_adder (
        .i_pc      (r_pc),
        .i_offset  (OFFSET),
        .o_pc_next (w_pc_next),
        .o_target  (w_target)
    );

    // Either busywait stalls; both together are still a single stall.
    assign w_busy   = BUSYWAIT | INSBUSYWAIT;
    assign w_retire = ((r_state == ST_RUN) || (r_state == ST_STALL)) && !w_busy;
    assign w_taken  = JUMP | (BRANCH_EQ & ALUZERO) | (BRANCH_NE & ~ALUZERO);

    // HALT wins over taken, so a halting instruction never counts as taken.
    assign w_cnt_inc[0] = w_retire;
    assign w_cnt_inc[1] = w_retire & ~HALT & w_taken;

    // Next-state decision; a retiring halt freezes the sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:   w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_busy)
                    w_state_next = ST_STALL;
                else if (HALT)
                    w_state_next = ST_HALTED;
            end
            ST_STALL: begin
                if (!w_busy)
                    w_state_next = HALT ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    // State register; reset overrides every state including HALTED.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_next;
    end

    // PC advances only on a retiring non-halt instruction.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_pc <= RESET_VEC;
        else if (w_retire && !HALT)
            r_pc <= w_taken ? w_target : w_pc_next;
    end

    // Saturating performance counters; they stick at all-ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge CLK) begin
                if (RESET)
                    r_cnt[gi] <= '0;
                else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}}))
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    endgenerate

    assign PC          = r_pc;
    assign PC_NEXT     = w_pc_next;
    assign FETCH_VALID = w_retire;
    assign STALL       = (r_state == ST_STALL);
    assign HALTED      = (r_state == ST_HALTED);
    assign RETIRE_CNT  = r_cnt[0];
    assign TAKEN_CNT   = r_cnt[1];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver computes the expected
// outputs of each cycle from a behavioural model and queues them; a monitor
// compares them against the DUT mid-cycle.
module tb_pc_sequencer;

    localparam int PC_W  = 32;
    localparam int OFF_W = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0, bw = 1'b0, ibw = 1'b0;
    logic             jmp = 1'b0, beq = 1'b0, bne = 1'b0, zf = 1'b0, hlt = 1'b0;
    logic [OFF_W-1:0] off = '0;
    logic [PC_W-1:0]  pc, pc_next;
    logic             fv, st, hl;
    logic [CNT_W-1:0] rc, tc;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W        (PC_W),
        .OFF_W       (OFF_W),
        .INSTR_BYTES (4),
        .ALIGN_SHIFT (2),
        .RESET_VEC   (32'h0),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .BUSYWAIT    (bw),
        .INSBUSYWAIT (ibw),
        .JUMP        (jmp),
        .BRANCH_EQ   (beq),
        .BRANCH_NE   (bne),
        .ALUZERO     (zf),
        .HALT        (hlt),
        .OFFSET      (off),
        .PC          (pc),
        .PC_NEXT     (pc_next),
        .FETCH_VALID (fv),
        .STALL       (st),
        .HALTED      (hl),
        .RETIRE_CNT  (rc),
        .TAKEN_CNT   (tc)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        fv;
        logic        st;
        logic        hl;
        int          rc;
        int          tc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cycle      = 0;

    // Behavioural model of the sequencer.
    logic [31:0] m_pc;
    int          m_rc, m_tc;
    bit          m_known   = 0;
    bit          m_booting = 0;
    bit          m_halted  = 0;
    bit          m_waiting = 0;

    // Apply one cycle of inputs, queue this cycle's expectation, advance model.
    task automatic step(input logic r, input logic b, input logic ib,
                        input logic j, input logic be, input logic bn,
                        input logic z, input logic h, input logic [7:0] o);
        exp_t e;
        bit   ret, tk;
        int   so;
        @(negedge clk);
        rst = r; bw = b; ibw = ib; jmp = j; beq = be; bne = bn;
        zf = z; hlt = h; off = o;
        cycle++;
        ret = m_known && !m_booting && !m_halted && !b && !ib;
        if (m_known) begin
            e.cyc = cycle; e.pc = m_pc; e.pc_next = m_pc + 32'd4;
            e.fv = ret; e.st = m_waiting; e.hl = m_halted;
            e.rc = m_rc; e.tc = m_tc;
            exp_q.push_back(e);
        end
        if (r) begin
            m_known = 1; m_pc = 32'h0; m_rc = 0; m_tc = 0;
            m_booting = 1; m_halted = 0; m_waiting = 0;
        end else if (m_known) begin
            if (m_booting) begin
                m_booting = 0;
            end else if (!m_halted) begin
                if (b || ib) begin
                    m_waiting = 1;
                end else begin
                    m_waiting = 0;
                    m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
                    tk = j || (be && z) || (bn && !z);
                    if (h) begin
                        m_halted = 1;
                    end else if (tk) begin
                        so = int'($signed(o));
                        m_pc = m_pc + 32'd4 + 32'(so * 4);
                        m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    function automatic void chk(input string name, input int cyc,
                                input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
        end
    endfunction

    // Monitor: mid-cycle, pop the expectation for this cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("pc",          e.cyc, pc,                e.pc);
                chk("pc_next",     e.cyc, pc_next,           e.pc_next);
                chk("fetch_valid", e.cyc, 32'(fv),           32'(e.fv));
                chk("stall",       e.cyc, 32'(st),           32'(e.st));
                chk("halted",      e.cyc, 32'(hl),           32'(e.hl));
                chk("retire_cnt",  e.cyc, 32'(rc),           32'(e.rc));
                chk("taken_cnt",   e.cyc, 32'(tc),           32'(e.tc));
                $display("cyc %0d pc=%08h fv=%0b st=%0b hl=%0b rc=%0d tc=%0d",
                         e.cyc, pc, fv, st, hl, rc, tc);
            end
        end
    end

    initial begin
        // Reset, boot, three sequential retires: 0 -> 4 -> 8 -> 12.
        step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h55);   // boot cycle, inputs ignored
        seq(3);
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);   // 12 -> 16
        step(0, 0, 0, 0, 1, 0, 1, 0, 8'hFE);   // beq taken: 0x10 -> 0x0C
        seq(1);                                // 0x0C -> 0x10
        step(0, 0, 0, 0, 0, 1, 1, 0, 8'hFE);   // bne not taken: -> 0x14
        step(0, 0, 0, 0, 1, 0, 0, 0, 8'h40);   // beq not taken: -> 0x18
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h01);   // 0x18 -> 0x20
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 1, 0, 0, 0, 0, 8'h02); // stall three cycles
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h02);   // retire: 0x20 -> 0x2C
        step(0, 1, 1, 0, 0, 0, 0, 1, 8'h00);   // both busy: single stall
        step(0, 0, 1, 0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'hF3);   // 0x2C -> 0xFFFFFFFC
        seq(1);                                // wrap to 0
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h0F);   // 0 -> 0x40
        step(0, 0, 0, 1, 0, 0, 0, 1, 8'h10);   // halt with jump
        for (int i = 0; i < 10; i++)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 1,
                 $urandom_range(0, 1), 0, 8'($urandom));
        step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);   // reset out of HALTED
        step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        seq(20);                               // drive retire counter to saturation
        step(0, 0, 1, 1, 0, 0, 0, 0, 8'h08);   // insbusywait stall
        step(0, 0, 1, 1, 0, 0, 0, 0, 8'h08);
        step(1, 0, 1, 1, 0, 0, 0, 0, 8'h08);   // reset mid-stall
        step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        seq(3);
        for (int i = 0; i < 20; i++)           // saturate taken counter
            step(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom_range(0, 3)));

        // Randomised traffic with occasional halts and resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1),
                 $urandom_range(0, 59) == 0,
                 8'($urandom));

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
